// File: rtl/lowrisc_hwrng_health.sv
// rtl/lowrisc_hwrng_health.sv - byte-level repetition/adaptive health tests on RNG FIFO words
// Reads one word per FIFO request, tests its four bytes, and delivers passing words on valid/ready.
module lowrisc_hwrng_health #(
  parameter int RD_LAT        = 3,
  parameter int RCT_CUTOFF    = 4,
  parameter int APT_WIN       = 512,
  parameter int APT_CUTOFF    = 13,
  parameter int STARTUP_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fifo_out_i,
  input  logic        empty_i,
  input  logic        rderr_i,
  input  logic        wrerr_i,
  output logic        rdfifo_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        clear_i,
  output logic        alarm_o,
  output logic        rct_fail_o,
  output logic        apt_fail_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
  localparam int APT_W  = $clog2(APT_WIN + 1);
  localparam int POS_W  = $clog2(APT_WIN);
  localparam int SU_W   = (STARTUP_WORDS > 0) ? $clog2(STARTUP_WORDS + 1) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0]  APT_MAX   = APT_W'(APT_WIN);
  localparam logic [APT_W-1:0]  APT_LIM   = APT_W'(APT_CUTOFF);
  localparam logic [SU_W-1:0]   SU_DONE   = SU_W'(STARTUP_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] TEST = 2'd3;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic [7:0]        prev_byte;
  logic [RCT_W-1:0]  rct_cnt;
  logic [7:0]        apt_ref;
  logic [APT_W-1:0]  apt_cnt;
  logic [POS_W-1:0]  apt_pos;
  logic [SU_W-1:0]   startup_cnt;

  logic [7:0]       cur_byte;
  logic             rct_match;
  logic [RCT_W-1:0] rct_nxt;
  logic             rct_hit;
  logic             apt_start;
  logic [APT_W-1:0] apt_nxt;
  logic             apt_hit;
  logic             startup_done;
  logic             drop;

  assign rdfifo_o = (state == REQ);
  assign alarm_o  = rct_fail_o | apt_fail_o;

  always_comb begin
    cur_byte = word[7:0];
    case (byte_idx)
      2'd0:    cur_byte = word[7:0];
      2'd1:    cur_byte = word[15:8];
      2'd2:    cur_byte = word[23:16];
      default: cur_byte = word[31:24];
    endcase
  end

  // rct_cnt == 0 only after reset/clear, so it doubles as the "no previous byte" flag
  assign rct_match = (rct_cnt != '0) && (cur_byte == prev_byte);
  assign rct_nxt   = !rct_match ? RCT_W'(1) :
                     (rct_cnt == RCT_MAX) ? rct_cnt : rct_cnt + RCT_W'(1);
  assign rct_hit   = (rct_nxt >= RCT_MAX);

  assign apt_start = (apt_pos == '0);
  assign apt_nxt   = apt_start ? APT_W'(1) :
                     ((cur_byte == apt_ref) && (apt_cnt != APT_MAX)) ? apt_cnt + APT_W'(1) : apt_cnt;
  assign apt_hit   = (apt_nxt > APT_LIM);

  assign startup_done = (startup_cnt == SU_DONE);
  // alarm_o already carries failures from earlier bytes of this word
  assign drop = alarm_o | rct_hit | apt_hit | !startup_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      word        <= '0;
      byte_idx    <= '0;
      prev_byte   <= '0;
      rct_cnt     <= '0;
      apt_ref     <= '0;
      apt_cnt     <= '0;
      apt_pos     <= '0;
      startup_cnt <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      rct_fail_o  <= 1'b0;
      apt_fail_o  <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
    end else begin
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (clear_i) begin
        state       <= IDLE;
        rct_cnt     <= '0;
        apt_cnt     <= '0;
        apt_pos     <= '0;
        startup_cnt <= '0;
        rct_fail_o  <= 1'b0;
        apt_fail_o  <= 1'b0;
        err_o       <= 1'b0;
      end else begin
        if (rderr_i || wrerr_i) err_o <= 1'b1;
        case (state)
          IDLE: begin
            if (!empty_i && !valid_o && !alarm_o) state <= REQ;
          end
          REQ: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              word     <= fifo_out_i;
              byte_idx <= '0;
              state    <= TEST;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
          TEST: begin
            prev_byte <= cur_byte;
            rct_cnt   <= rct_nxt;
            apt_cnt   <= apt_nxt;
            apt_pos   <= apt_pos + POS_W'(1);
            byte_idx  <= byte_idx + 2'd1;
            if (apt_start) apt_ref <= cur_byte;
            if (rct_hit) rct_fail_o <= 1'b1;
            if (apt_hit) apt_fail_o <= 1'b1;
            if (byte_idx == 2'd3) begin
              state <= IDLE;
              if (!startup_done) startup_cnt <= startup_cnt + SU_W'(1);
              if (!drop) begin
                data_o  <= word;
                valid_o <= 1'b1;
                if (words_o != 16'hFFFF) words_o <= words_o + 16'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/lowrisc_hwrng_health.md
LOWRISC_HWRNG_HEALTH -- requirements
Module: lowrisc_hwrng_health

Downstream consumer of the hardware RNG FIFO: reads 32-bit words, runs byte-level health tests, and presents passing words on a valid/ready port.

Interface
REQ-001 SHALL have parameter RD_LAT, default 3: cycles from rdfifo_o pulse to valid fifo_out_i (1 edge-detect register plus 2 FIFO output stages).
REQ-002 SHALL have parameter RCT_CUTOFF, default 4: count of identical consecutive bytes that trips the repetition test.
REQ-003 SHALL have parameter APT_WIN, default 512: adaptive-proportion window in bytes, power of two.
REQ-004 SHALL have parameter APT_CUTOFF, default 13: matches within a window that trips the adaptive test.
REQ-005 SHALL have parameter STARTUP_WORDS, default 4: words tested but discarded after reset or clear.
REQ-006 SHALL use one clock; reset is synchronous and active-high: clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-007 SHALL have the following ports:
- fifo_out_i, in, 32: FIFO read data.
- empty_i, in, 1: FIFO empty.
- rderr_i, in, 1: FIFO read error.
- wrerr_i, in, 1: FIFO write error.
- rdfifo_o, out, 1: read request, one-cycle pulse.
- data_o, out, 32: tested word.
- valid_o, out, 1: data_o valid.
- ready_i, in, 1: consumer accepts.
- clear_i, in, 1: clear alarms and restart tests.
- alarm_o, out, 1: sticky, rct_fail_o OR apt_fail_o.
- rct_fail_o, out, 1: sticky.
- apt_fail_o, out, 1: sticky.
- err_o, out, 1: sticky FIFO error.
- words_o, out, 16: saturating count of words delivered.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, TEST.
REQ-009 SHALL, in IDLE, go to REQ when empty_i=0, valid_o=0, alarm_o=0 and clear_i=0; otherwise it SHALL stay in IDLE.
REQ-010 SHALL drive rdfifo_o=1 only in REQ, for exactly one cycle, then go to WAIT; rdfifo_o SHALL be 0 for at least RD_LAT+4 cycles between pulses.
REQ-011 SHALL capture fifo_out_i into an internal word register exactly RD_LAT cycles after the REQ cycle, then go to TEST.
REQ-012 SHALL, in TEST, process bytes [7:0], [15:8], [23:16], [31:24] in that order, one byte per cycle, for 4 cycles.
REQ-013 Repetition test: on each byte, if it equals the previous byte then rct_cnt++, else rct_cnt=1; when rct_cnt reaches RCT_CUTOFF, rct_fail_o SHALL set.
REQ-014 Repetition test: the first byte after reset or clear SHALL only load the previous-byte register, with rct_cnt=1.
REQ-015 Adaptive test: the first byte of each window SHALL become the reference with apt_cnt=1; each later byte equal to the reference SHALL do apt_cnt++.
REQ-016 Adaptive test: when apt_cnt exceeds APT_CUTOFF, apt_fail_o SHALL set; after APT_WIN bytes the window SHALL restart, and the window byte counter SHALL wrap modulo APT_WIN.
REQ-017 SHALL, at the end of TEST, drop the word if any failure was set during this word or the startup counter is below STARTUP_WORDS (then startup counter++); otherwise it SHALL load data_o, set valid_o=1 and do words_o++ (saturating at 16'hFFFF). Next state SHALL be IDLE in all cases.
REQ-018 SHALL hold valid_o and data_o stable until valid_o && ready_i, and SHALL clear valid_o on the cycle after that handshake.
REQ-019 SHALL set err_o on any cycle with rderr_i or wrerr_i high, regardless of state.
REQ-020 clear_i SHALL, in one cycle, clear alarm_o, rct_fail_o, apt_fail_o, err_o, rct_cnt, the APT window and the startup counter, force IDLE and discard any in-flight word; data_o, valid_o and words_o SHALL be unaffected.
REQ-021 clear_i SHALL take priority over a failure or error detected in the same cycle.
REQ-022 With alarm_o=1, SHALL issue no new reads; an already-captured word SHALL be discarded.
REQ-023 empty_i SHALL be sampled only in IDLE; a stale empty_i=0 that yields an underflow read SHALL be caught by rderr_i and reported via err_o, and the captured word SHALL still be tested.

Reset
REQ-024 With rst_i=1 at a clk_i edge, SHALL set state IDLE; rdfifo_o, valid_o, alarm_o, rct_fail_o, apt_fail_o, err_o = 0; data_o = 0; words_o = 0; all counters 0.
REQ-025 Reset asserted mid-read SHALL discard the pending word; the FIFO is reset independently by its owner.

Verification
REQ-026 Reset then 6 distinct-byte words queued (empty_i=0) -> 4 pulses with no valid_o; 5th word appears on data_o; words_o=1 after handshake.
REQ-027 Word 32'hAAAAAAAA after startup -> rct_fail_o=1 and alarm_o=1 on the 4th TEST cycle; word not output; rdfifo_o stays 0.
REQ-028 Byte 8'h5A injected 14 times within one 512-byte window among otherwise distinct bytes -> apt_fail_o=1 on the 14th match.
REQ-029 ready_i=0 for 20 cycles with valid_o=1 -> data_o stable, no rdfifo_o pulse; ready_i=1 -> valid_o=0 next cycle, next read follows.
REQ-030 rderr_i pulse in WAIT plus clear_i in the same cycle as a trip -> err_o and alarm_o read 0 afterwards; startup counter restarts (next 4 words dropped).
REQ-031 rst_i asserted during WAIT -> all outputs 0 the next cycle; no capture occurs at the RD_LAT point.
